// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath widths, ALU op classes and the
// all-zero control bundle used for bubbles.
package core_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       branch;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '{alu_op: ALU_OP_ADD, default: 1'b0};

endpackage

// File: rtl/id_ex_bypass_mux.sv
// Per-operand writeback bypass select: returns wb_data when the WB port writes
// the register named by src_addr (never x0), otherwise src_data.
module id_ex_bypass_mux #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic [XLEN-1:0]   src_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   byp_data
);

  logic hit;

  assign hit      = wb_reg_write && (wb_rd_addr != '0) && (wb_rd_addr == src_addr);
  assign byp_data = hit ? wb_data : src_data;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall, flush, WB bypass and held-operand refresh.
// Optional load-use bubble insertion when ID_EX_LOAD_USE_DETECT_EN is defined.
module id_ex_pipe_reg
  import core_pkg::*;
#(
  parameter int XLEN   = core_pkg::XLEN,
  parameter int REG_AW = core_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              id_mem_to_reg,
  input  logic              id_branch,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output logic [REG_AW-1:0] ex_rs1_addr,
  output logic [REG_AW-1:0] ex_rs2_addr,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_branch,
  output logic              hazard_stall_o
);

  ex_ctrl_t          id_ctrl, load_ctrl, ex_ctrl_q;
  logic [REG_AW-1:0] rs1_src_addr, rs2_src_addr;
  logic [XLEN-1:0]   rs1_src_data, rs2_src_data;
  logic [XLEN-1:0]   rs1_byp_data, rs2_byp_data;
  logic              load_use_bubble;

  assign id_ctrl = '{alu_op: id_alu_op, alu_src: id_alu_src, mem_read: id_mem_read,
                     mem_write: id_mem_write, reg_write: id_reg_write,
                     mem_to_reg: id_mem_to_reg, branch: id_branch};
  assign load_ctrl = id_valid ? id_ctrl : BUBBLE_CTRL;

  // While stalled the same mux refreshes the held operands against EX's own addresses.
  assign rs1_src_addr = stall_i ? ex_rs1_addr : id_rs1_addr;
  assign rs2_src_addr = stall_i ? ex_rs2_addr : id_rs2_addr;
  assign rs1_src_data = stall_i ? ex_rs1_data : id_rs1_data;
  assign rs2_src_data = stall_i ? ex_rs2_data : id_rs2_data;

  id_ex_bypass_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_byp_rs1 (
    .src_addr     (rs1_src_addr),
    .src_data     (rs1_src_data),
    .wb_reg_write (wb_reg_write),
    .wb_rd_addr   (wb_rd_addr),
    .wb_data      (wb_data),
    .byp_data     (rs1_byp_data)
  );

  id_ex_bypass_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_byp_rs2 (
    .src_addr     (rs2_src_addr),
    .src_data     (rs2_src_data),
    .wb_reg_write (wb_reg_write),
    .wb_rd_addr   (wb_rd_addr),
    .wb_data      (wb_data),
    .byp_data     (rs2_byp_data)
  );

`ifdef ID_EX_LOAD_USE_DETECT_EN
  assign hazard_stall_o = id_valid & ex_valid & ex_ctrl_q.mem_read & (ex_rd_addr != '0) &
                          ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));
  assign load_use_bubble = hazard_stall_o;
`else
  assign hazard_stall_o  = 1'b0;
  assign load_use_bubble = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || flush_i || (load_use_bubble && !stall_i)) begin
      ex_valid    <= 1'b0;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1_addr <= '0;
      ex_rs2_addr <= '0;
      ex_rd_addr  <= '0;
      ex_funct3   <= '0;
      ex_funct7   <= '0;
      ex_ctrl_q   <= BUBBLE_CTRL;
    end else if (stall_i) begin
      ex_rs1_data <= rs1_byp_data;
      ex_rs2_data <= rs2_byp_data;
    end else begin
      ex_valid    <= id_valid;
      ex_pc       <= id_pc;
      ex_rs1_data <= rs1_byp_data;
      ex_rs2_data <= rs2_byp_data;
      ex_imm      <= id_imm;
      ex_rs1_addr <= id_rs1_addr;
      ex_rs2_addr <= id_rs2_addr;
      ex_rd_addr  <= id_rd_addr;
      ex_funct3   <= id_funct3;
      ex_funct7   <= id_funct7;
      ex_ctrl_q   <= load_ctrl;
    end
  end

  assign ex_alu_op     = ex_ctrl_q.alu_op;
  assign ex_alu_src    = ex_ctrl_q.alu_src;
  assign ex_mem_read   = ex_ctrl_q.mem_read;
  assign ex_mem_write  = ex_ctrl_q.mem_write;
  assign ex_reg_write  = ex_ctrl_q.reg_write;
  assign ex_mem_to_reg = ex_ctrl_q.mem_to_reg;
  assign ex_branch     = ex_ctrl_q.branch;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: per-cycle expectations from a reference model go
// into a scoreboard queue and are compared after each clock edge.
module tb_id_ex_pipe_reg;

  typedef struct {
    logic        rst_n, stall, flush, valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rda;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1a, rs2a, rda;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [1:0]  alu_op;
    logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch;
  } exp_t;

  logic  clk = 1'b0;
  in_t   din;
  exp_t  mdl = '0;
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;

  logic        ex_valid, ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write;
  logic        ex_mem_to_reg, ex_branch, hazard_stall_o;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [1:0]  ex_alu_op;

  always #5 clk = ~clk;

  id_ex_pipe_reg dut (
    .clk(clk), .rst_n(din.rst_n), .stall_i(din.stall), .flush_i(din.flush),
    .id_valid(din.valid), .id_pc(din.pc), .id_rs1_data(din.rs1d), .id_rs2_data(din.rs2d),
    .id_imm(din.imm), .id_rs1_addr(din.rs1a), .id_rs2_addr(din.rs2a), .id_rd_addr(din.rda),
    .id_funct3(din.f3), .id_funct7(din.f7), .id_alu_op(din.alu_op), .id_alu_src(din.alu_src),
    .id_mem_read(din.mem_read), .id_mem_write(din.mem_write), .id_reg_write(din.reg_write),
    .id_mem_to_reg(din.mem_to_reg), .id_branch(din.branch),
    .wb_reg_write(din.wb_we), .wb_rd_addr(din.wb_rd), .wb_data(din.wb_data),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr), .ex_rd_addr(ex_rd_addr),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .hazard_stall_o(hazard_stall_o)
  );

  function automatic exp_t sample();
    return '{valid: ex_valid, pc: ex_pc, rs1d: ex_rs1_data, rs2d: ex_rs2_data, imm: ex_imm,
             rs1a: ex_rs1_addr, rs2a: ex_rs2_addr, rda: ex_rd_addr, f3: ex_funct3, f7: ex_funct7,
             alu_op: ex_alu_op, alu_src: ex_alu_src, mem_read: ex_mem_read,
             mem_write: ex_mem_write, reg_write: ex_reg_write, mem_to_reg: ex_mem_to_reg,
             branch: ex_branch};
  endfunction

  function automatic logic model_hz(input exp_t m, input in_t d);
`ifdef ID_EX_LOAD_USE_DETECT_EN
    return d.valid && m.valid && m.mem_read && (m.rda != 5'd0) &&
           ((m.rda == d.rs1a) || (m.rda == d.rs2a));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic wb_match(input in_t d, input logic [4:0] a);
    return d.wb_we && (d.wb_rd != 5'd0) && (d.wb_rd == a);
  endfunction

  // Expected EX contents after the next edge, given current EX contents and inputs.
  function automatic exp_t model_next(input exp_t q, input in_t d);
    exp_t n = q;
    if (!d.rst_n || d.flush) n = '0;
    else if (d.stall) begin
      if (wb_match(d, q.rs1a)) n.rs1d = d.wb_data;
      if (wb_match(d, q.rs2a)) n.rs2d = d.wb_data;
    end else if (model_hz(q, d)) n = '0;
    else begin
      n = '{valid: d.valid, pc: d.pc, rs1d: wb_match(d, d.rs1a) ? d.wb_data : d.rs1d,
            rs2d: wb_match(d, d.rs2a) ? d.wb_data : d.rs2d, imm: d.imm, rs1a: d.rs1a,
            rs2a: d.rs2a, rda: d.rda, f3: d.f3, f7: d.f7, alu_op: 2'b00, alu_src: 1'b0,
            mem_read: 1'b0, mem_write: 1'b0, reg_write: 1'b0, mem_to_reg: 1'b0, branch: 1'b0};
      if (d.valid) begin
        n.alu_op = d.alu_op;   n.alu_src = d.alu_src;     n.mem_read = d.mem_read;
        n.mem_write = d.mem_write; n.reg_write = d.reg_write;
        n.mem_to_reg = d.mem_to_reg; n.branch = d.branch;
      end
    end
    return n;
  endfunction

  function automatic in_t rand_in();
    in_t d;
    d.rst_n = 1'b1; d.stall = 1'b0; d.flush = 1'b0; d.valid = 1'($urandom);
    d.pc = $urandom; d.rs1d = $urandom; d.rs2d = $urandom; d.imm = $urandom;
    d.rs1a = 5'($urandom); d.rs2a = 5'($urandom); d.rda = 5'($urandom);
    d.f3 = 3'($urandom); d.f7 = 7'($urandom); d.alu_op = 2'($urandom_range(0, 2));
    d.alu_src = 1'($urandom); d.mem_read = 1'b0; d.mem_write = 1'($urandom);
    d.reg_write = 1'($urandom); d.mem_to_reg = 1'($urandom); d.branch = 1'($urandom);
    d.wb_we = 1'b0; d.wb_rd = 5'd0; d.wb_data = $urandom;
    return d;
  endfunction

  task automatic tick();
    exp_t n;
    n = model_next(mdl, din);
    sb.push_back(n);
    mdl = n;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    din = rand_in(); din.rst_n = 1'b0; din.valid = 1'b1; din.stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e || o !== '0) begin
        errors++; $display("FAIL reset: got %h expected %h", o, e);
      end
    end
  endtask

  task automatic test_reset_load();
    exp_t e, o;
    din = rand_in(); din.valid = 1'b1; din.alu_op = 2'b10; din.f3 = 3'b000;
    din.f7 = 7'b0100000; din.rs1d = 32'd5;
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL first_load: got %h expected %h", o, e); end
    checks++;
    if (ex_alu_op !== 2'b10 || ex_funct7 !== 7'h20 || ex_rs1_data !== 32'd5 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_load_fields: alu_op=%b f7=%h rs1=%h valid=%b, expected 10 20 5 1",
               ex_alu_op, ex_funct7, ex_rs1_data, ex_valid);
    end
  endtask

  task automatic test_stall_refresh();
    exp_t e, o, held;
    din = rand_in(); din.valid = 1'b1; din.rs1a = 5'd4; din.rs2a = 5'd7;
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL stall_preload: got %h expected %h", o, e); end
    held = o;
    for (int c = 1; c <= 3; c++) begin
      din = rand_in(); din.stall = 1'b1; din.wb_we = 1'b1;
      din.wb_rd = (c == 2) ? 5'd7 : 5'd9;
      din.wb_data = (c == 2) ? 32'hDEAD : 32'h0BAD_0BAD;
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL stall_cycle%0d: got %h expected %h", c, o, e); end
    end
    din = rand_in(); #1;
    checks++;
    if (ex_rs2_data !== 32'hDEAD || ex_rs1_data !== held.rs1d || ex_pc !== held.pc ||
        ex_imm !== held.imm || ex_valid !== held.valid) begin
      errors++;
      $display("FAIL stall_hold: rs2=%h rs1=%h pc=%h expected rs2=0000dead rs1=%h pc=%h",
               ex_rs2_data, ex_rs1_data, ex_pc, held.rs1d, held.pc);
    end
  endtask

  task automatic test_flush_stall();
    exp_t e, o;
    din = rand_in(); din.valid = 1'b1; din.reg_write = 1'b1; din.mem_write = 1'b1; din.alu_op = 2'b10;
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL flush_preload: got %h expected %h", o, e); end
    din = rand_in(); din.valid = 1'b1; din.stall = 1'b1; din.flush = 1'b1;
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 ||
        ex_alu_op !== 2'b00) begin
      errors++; $display("FAIL flush_over_stall: got %h expected %h", o, e);
    end
  endtask

  task automatic test_bypass();
    exp_t e, o;
    din = rand_in(); din.valid = 1'b1; din.rs1a = 5'd3; din.rs2a = 5'd3;
    din.wb_we = 1'b1; din.wb_rd = 5'd3; din.wb_data = 32'h1234;
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || ex_rs1_data !== 32'h1234 || ex_rs2_data !== 32'h1234) begin
      errors++; $display("FAIL bypass_both: rs1=%h rs2=%h expected 00001234 both", ex_rs1_data, ex_rs2_data);
    end
    din = rand_in(); din.valid = 1'b1; din.rs1a = 5'd0; din.rs2a = 5'd0;
    din.rs1d = 32'hAAAA_0001; din.rs2d = 32'hBBBB_0002;
    din.wb_we = 1'b1; din.wb_rd = 5'd0; din.wb_data = 32'h1234;
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || ex_rs1_data !== 32'hAAAA_0001 || ex_rs2_data !== 32'hBBBB_0002) begin
      errors++; $display("FAIL bypass_x0: rs1=%h rs2=%h expected aaaa0001 bbbb0002", ex_rs1_data, ex_rs2_data);
    end
    din = rand_in(); din.valid = 1'b1; din.rs1a = 5'd6; din.rs2a = 5'd8;
    din.rs2d = 32'h0000_5678; din.wb_we = 1'b1; din.wb_rd = 5'd6; din.wb_data = 32'hCAFE;
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || ex_rs1_data !== 32'hCAFE || ex_rs2_data !== 32'h5678) begin
      errors++; $display("FAIL bypass_rs1_only: rs1=%h rs2=%h expected 0000cafe 00005678", ex_rs1_data, ex_rs2_data);
    end
  endtask

  task automatic test_invalid();
    exp_t e, o;
    din = rand_in(); din.valid = 1'b0; din.reg_write = 1'b1; din.mem_write = 1'b1;
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0 || ex_valid !== 1'b0) begin
      errors++; $display("FAIL invalid_ctrl: got %h expected %h", o, e);
    end
  endtask

  task automatic test_load_use();
    exp_t e, o;
    din = rand_in(); din.valid = 1'b1; din.mem_read = 1'b1; din.rda = 5'd5;
    din.reg_write = 1'b1; din.mem_to_reg = 1'b1; din.rs1a = 5'd1; din.rs2a = 5'd2;
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL lw_load: got %h expected %h", o, e); end
    din = rand_in(); din.valid = 1'b1; din.rs1a = 5'd6; din.rs2a = 5'd5; din.rda = 5'd10;
    din.alu_op = 2'b10; din.reg_write = 1'b1;
    #1;
    checks++;
`ifdef ID_EX_LOAD_USE_DETECT_EN
    if (hazard_stall_o !== 1'b1) begin errors++; $display("FAIL hazard_flag: got %b expected 1", hazard_stall_o); end
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || ex_valid !== 1'b0) begin errors++; $display("FAIL load_use_bubble: got %h expected %h", o, e); end
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || ex_valid !== 1'b1 || ex_rs2_addr !== 5'd5 || ex_rd_addr !== 5'd10) begin
      errors++; $display("FAIL load_use_add: got %h expected %h", o, e);
    end
`else
    if (hazard_stall_o !== 1'b0) begin errors++; $display("FAIL hazard_flag: got %b expected 0", hazard_stall_o); end
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || ex_valid !== 1'b1 || ex_rs2_addr !== 5'd5 || ex_rd_addr !== 5'd10) begin
      errors++; $display("FAIL load_use_add: got %h expected %h", o, e);
    end
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e, o;
    logic hz;
    for (int i = 0; i < 60; i++) begin
      din = rand_in();
      din.rs1a = 5'($urandom_range(0, 3)); din.rs2a = 5'($urandom_range(0, 3));
      din.rda = 5'($urandom_range(0, 3)); din.mem_read = 1'($urandom);
      din.wb_we = 1'($urandom); din.wb_rd = 5'($urandom_range(0, 3));
      din.stall = ($urandom_range(0, 3) == 0); din.flush = ($urandom_range(0, 7) == 0);
      din.rst_n = ($urandom_range(0, 15) != 0);
      #1;
      hz = model_hz(mdl, din); checks++;
      if (hazard_stall_o !== hz) begin
        errors++; $display("FAIL b2b_hazard[%0d]: got %b expected %b", i, hazard_stall_o, hz);
      end
      tick();
      e = sb.pop_front(); o = sample(); checks++;
      if (o !== e) begin errors++; $display("FAIL b2b[%0d]: got %h expected %h", i, o, e); end
    end
    din = rand_in(); din.valid = 1'b1;
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e) begin errors++; $display("FAIL pre_reset_load: got %h expected %h", o, e); end
    din = rand_in(); din.stall = 1'b1; din.rst_n = 1'b0; din.wb_we = 1'b1; din.wb_rd = mdl.rs1a;
    tick();
    e = sb.pop_front(); o = sample(); checks++;
    if (o !== e || o !== '0) begin errors++; $display("FAIL reset_mid_stall: got %h expected %h", o, e); end
  endtask

  initial begin
    din = rand_in(); din.rst_n = 1'b0;
    test_reset();
    test_reset_load();
    test_stall_refresh();
    test_flush_stall();
    test_bypass();
    test_invalid();
    test_load_use();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32I core; sits directly upstream of the EX stage.
- Captures decoded control (alu_op, funct3, funct7, memory/writeback controls), operands, immediate and register addresses from ID, and presents them to EX (ALU control decode, ALU, branch compare).
- Handles stall, flush/bubble insertion, and WB-to-ID operand bypass, including refresh of held operands while stalled.

Parameters:
- XLEN, 32, datapath width of pc/operands/immediate.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall_i  in  1  hold current EX contents.
- flush_i  in  1  replace EX contents with bubble (branch taken/jump).
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_AW  register addresses.
- id_funct3  in  3; id_funct7  in  7  instruction fields.
- id_alu_op  in  2  ALU op class (00 add, 01 sub/branch, 10 R/I-type decode).
- id_alu_src, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg, id_branch  in  1 each  control bits.
- wb_reg_write  in  1; wb_rd_addr  in  REG_AW; wb_data  in  XLEN  writeback port.
- ex_valid  out  1; ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN.
- ex_rs1_addr, ex_rs2_addr, ex_rd_addr  out  REG_AW.
- ex_funct3  out  3; ex_funct7  out  7; ex_alu_op  out  2.
- ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch  out  1 each.
- hazard_stall_o  out  1  load-use stall request to PC/IF-ID (feature-dependent).

Behaviour:
- All outputs are registered except hazard_stall_o; latency ID to EX is 1 cycle.
- Reset (rst_n=0 at posedge): every registered output is 0, including ex_valid=0 and ex_alu_op=2'b00.
- Update priority at each posedge: reset > flush_i > stall_i > bubble (hazard) > load.
- Flush and bubble: ex_valid=0; ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_mem_to_reg, ex_alu_src=0; ex_alu_op=00; all data, address and funct fields=0.
- Load: every ex_* takes its id_* value; ex_valid=id_valid.
- If id_valid=0 on load, control bits are forced to 0 as for a bubble.
- WB bypass on load: wb_reg_write=1 and wb_rd_addr!=0 and wb_rd_addr==id_rs1_addr gives ex_rs1_data=wb_data; rs2 uses the same rule independently; both can hit simultaneously.
- Held refresh on stall: while stall_i=1, the same bypass rule is applied against ex_rs1_addr/ex_rs2_addr; the matching ex_rsX_data is overwritten with wb_data; all other fields hold.
- x0 is never bypassed.
- Flush and stall asserted together: flush wins.
- Reset mid-stall: reset wins, outputs zeroed.

Optional Feature:
- Macro: ID_EX_LOAD_USE_DETECT_EN.
- Defined: hazard_stall_o = id_valid & ex_valid & ex_mem_read & (ex_rd_addr!=0) & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr), combinational. When it is 1 and neither flush_i nor stall_i is set, the next posedge inserts a bubble. The ID instruction is re-presented by the upstream stall.
- Not defined: hazard_stall_o tied to 0; no internal bubble insertion. The external hazard unit drives stall_i/flush_i.

Decomposition:
- Shared package core_pkg holds:
  - XLEN and REG_AW.
  - ALU_OP_ADD=2'b00, ALU_OP_SUB=2'b01, ALU_OP_FUNCT=2'b10.
  - A bubble-control constant (all-zero control bundle).
- One sub-module is natural: id_ex_bypass_mux, the per-operand WB-match select, instantiated twice (load path and held path share it via an address select).

Test Plan:
- Reset then load: hold rst_n=0 for 2 cycles, then load id_alu_op=10, id_funct3=000, id_funct7=0100000, id_valid=1, id_rs1_data=5 -> after reset all outputs 0; next cycle ex_alu_op=10, ex_funct7=0x20, ex_rs1_data=5, ex_valid=1.
- Stall hold and refresh: stall_i=1 for 3 cycles, with wb_reg_write=1, wb_rd_addr=ex_rs2_addr=7, wb_data=0xDEAD in cycle 2 -> all fields hold, ex_rs2_data becomes 0xDEAD, and it stays 0xDEAD after the stall releases.
- Flush during stall: flush_i=1 and stall_i=1 together -> ex_valid=0, ex_reg_write=0, ex_mem_write=0, ex_alu_op=00.
- Bypass: id_rs1_addr=id_rs2_addr=3 with wb writing x3=0x1234 -> both ex_rs1_data and ex_rs2_data=0x1234. The same with rd=x0 -> no bypass, id data passes.
- Load-use (macro defined): EX holds lw x5 (ex_mem_read=1, ex_rd_addr=5), ID holds add using rs2=x5 -> hazard_stall_o=1 in the same cycle; next cycle ex_valid=0 bubble; the following cycle the add loads. Macro undefined -> hazard_stall_o=0 and the add loads immediately.
- Invalid instruction: id_valid=0 with id_reg_write=1, id_mem_write=1 -> ex_reg_write=0, ex_mem_write=0, ex_valid=0.
